regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port register file with a per-register pending-write scoreboard and a sequential clear engine. Successor to the single-issue CPU register file, sitting between decode/issue and writeback in the pipelined core. Decode reads operands and their busy flags, issue reserves destination registers, and writeback retires them. Register 0 is hardwired to zero.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (power of two, ≥4); AW = $clog2(REG_NUM)
- REG_SIZE, 32, register data width in bits
- READ_PORTS, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback forwarding to read ports; 0 = none

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  READ_PORTS*AW  read addresses; port i at [i*AW +: AW]
- rd_data  out  READ_PORTS*REG_SIZE  read data; port i at [i*REG_SIZE +: REG_SIZE]
- rd_busy  out  READ_PORTS  scoreboard flag of addressed register, per port
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  REG_SIZE  writeback data
- iss_en  in  1  issue strobe: reserve iss_addr as pending
- iss_addr  in  AW  destination being reserved
- iss_ready  out  1  issue accepted this cycle if iss_en high
- clr_req  in  1  start sequential clear of all registers
- clr_busy  out  1  clear engine running

## Operation
- Storage: REG_NUM-1 data registers (1..REG_NUM-1) plus REG_NUM-1 busy bits; index 0 has no storage.
- Reads: combinational. rd_addr = 0 -> rd_data 0, rd_busy 0. Otherwise stored value and busy bit.
- Bypass (BYPASS=1): if wr_en, wr_addr = rd_addr ≠ 0 and state IDLE -> rd_data = wr_data, rd_busy = 0 for that port. BYPASS=0: writes are visible only from the next cycle.
- Write: in IDLE, wr_en with wr_addr ≠ 0 stores wr_data and clears busy[wr_addr]. A write to 0 is ignored. A write to a non-busy register is still performed.
- Issue: iss_ready = IDLE and (iss_addr = 0 or busy[iss_addr] = 0 or (wr_en and wr_addr = iss_addr)). This stalls on a WAW hazard unless that register retires in the same cycle. When iss_en and iss_ready with iss_addr ≠ 0, busy[iss_addr] is set. iss_en with iss_ready = 0 has no effect.
- Simultaneous wr_en and accepted iss_en to the same address: data is written and busy ends up 1 (the new reservation wins).
- FSM states:
  - IDLE -> CLEAR on clr_req.
  - CLEAR holds counter idx, starting at 1. Each cycle it zeroes data[idx] and busy[idx], then increments idx.
  - CLEAR -> IDLE after idx = REG_NUM-1 is cleared.
- In CLEAR:
  - wr_en, iss_en and clr_req are ignored; clr_busy = 1; iss_ready = 0.
  - Reads return stored contents: registers not yet cleared keep their old values, and the bypass is disabled.

## Timing
- Reset (async assert) values: all data 0, all busy 0, state IDLE, idx 1. Outputs: clr_busy 0, iss_ready 1, rd_data 0, rd_busy 0 on every port.
- Reset asserted mid-CLEAR aborts the clear immediately and returns to IDLE.
- Write latency: stored value appears on rd_data 1 cycle after the wr_en edge, or in the same cycle when BYPASS = 1.
- Busy set by issue is visible on rd_busy in the cycle after acceptance.
- Clear: clr_busy goes high the cycle after the clr_req edge and stays high for exactly REG_NUM-1 cycles. iss_ready returns to 1 in the following cycle.
- All read ports are independent; the same address on several ports returns identical data and busy.

## Test plan
- Reset, then write 0xDEADBEEF to r5. Next cycle, read r5 on port 0 and r0 on port 1 -> 0xDEADBEEF and 0, rd_busy = 00.
- BYPASS=1: in the same cycle, wr_en r7 = 0x12345678 while rd_addr0 = 7 -> rd_data0 = 0x12345678, rd_busy0 = 0. BYPASS=0 build: returns the old value 0.
- Issue r3 (accepted) -> next cycle rd_busy for r3 = 1. Issue r3 again -> iss_ready = 0, busy stays 1. Issue r3 with a simultaneous wr_en r3 -> accepted, data written, busy = 1.
- Issue r0 and write r0 = 0xFFFFFFFF -> iss_ready = 1, r0 reads 0 with busy 0.
- Fill r1..r31 with nonzero values and busy bits, pulse clr_req:
  - clr_busy is high for 31 cycles, iss_ready = 0, and writes are ignored.
  - Afterwards every register reads 0 with busy 0.
- Assert rst asynchronously (between edges) mid-clear at idx = 10 -> outputs reset immediately, all registers 0, state IDLE, iss_ready 1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with a per-register pending-write scoreboard and a
// sequential clear engine; register 0 reads as zero and is never busy.
module regfile_scoreboard #(
    parameter int REG_NUM    = 32,
    parameter int REG_SIZE   = 32,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(REG_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [READ_PORTS*AW-1:0]       rd_addr,
    output logic [READ_PORTS*REG_SIZE-1:0] rd_data,
    output logic [READ_PORTS-1:0]          rd_busy,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [REG_SIZE-1:0]            wr_data,
    input  logic                           iss_en,
    input  logic [AW-1:0]                  iss_addr,
    output logic                           iss_ready,
    input  logic                           clr_req,
    output logic                           clr_busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] IDX_FIRST = AW'(1);
    localparam logic [AW-1:0] IDX_LAST  = AW'(REG_NUM - 1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW-1:0]         r_idx;
    logic [REG_SIZE-1:0]   r_data [1:REG_NUM-1];
    logic [REG_NUM-1:1]    r_busy;

    // Index 0 of the view arrays is the hardwired zero register.
    logic [REG_SIZE-1:0]   w_file_data [REG_NUM];
    logic [REG_NUM-1:0]    w_file_busy;
    logic                  w_bypass_en;
    logic                  w_iss_ready;

    assign w_file_data[0] = {REG_SIZE{1'b0}};
    assign w_file_busy[0] = 1'b0;

    genvar g;
    generate
        for (g = 1; g < REG_NUM; g++) begin : g_view
            assign w_file_data[g] = r_data[g];
            assign w_file_busy[g] = r_busy[g];
        end
    endgenerate

    assign w_bypass_en = (BYPASS != 0) && (r_state == ST_IDLE) && wr_en && (wr_addr != ADDR_ZERO);

    // A register retiring this cycle frees its slot for a new reservation.
    assign w_iss_ready = (r_state == ST_IDLE) &&
                         ((iss_addr == ADDR_ZERO) || !w_file_busy[iss_addr] ||
                          (wr_en && (wr_addr == iss_addr)));

    assign iss_ready = w_iss_ready;
    assign clr_busy  = (r_state == ST_CLEAR);

    // Read ports: forwarded writeback data, otherwise the stored entry.
    always_comb begin
        rd_data = {(READ_PORTS*REG_SIZE){1'b0}};
        rd_busy = {READ_PORTS{1'b0}};
        for (int p = 0; p < READ_PORTS; p++) begin
            if (w_bypass_en && (wr_addr == rd_addr[p*AW +: AW])) begin
                rd_data[p*REG_SIZE +: REG_SIZE] = wr_data;
                rd_busy[p]                      = 1'b0;
            end else begin
                rd_data[p*REG_SIZE +: REG_SIZE] = w_file_data[rd_addr[p*AW +: AW]];
                rd_busy[p]                      = w_file_busy[rd_addr[p*AW +: AW]];
            end
        end
    end

    // Next-state logic for the clear engine.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and clear index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= IDX_FIRST;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_CLEAR) && (r_idx != IDX_LAST)) begin
                r_idx <= r_idx + AW'(1);
            end else begin
                r_idx <= IDX_FIRST;
            end
        end
    end

    // Register storage and scoreboard; an accepted issue overrides a same-cycle retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k < REG_NUM; k++) begin
                r_data[k] <= {REG_SIZE{1'b0}};
            end
            r_busy <= {(REG_NUM-1){1'b0}};
        end else if (r_state == ST_CLEAR) begin
            for (int k = 1; k < REG_NUM; k++) begin
                if (r_idx == AW'(k)) begin
                    r_data[k] <= {REG_SIZE{1'b0}};
                    r_busy[k] <= 1'b0;
                end
            end
        end else begin
            for (int k = 1; k < REG_NUM; k++) begin
                if (wr_en && (wr_addr == AW'(k))) begin
                    r_data[k] <= wr_data;
                    r_busy[k] <= 1'b0;
                end
                if (iss_en && w_iss_ready && (iss_addr == AW'(k))) begin
                    r_busy[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a reference model feeds a queue of
// expected {busy,data} read results that are popped when the DUT is sampled.
module tb_regfile_scoreboard;

    localparam int RN = 32;
    localparam int RS = 32;
    localparam int RP = 2;
    localparam int AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [RP*AW-1:0]  rd_addr;
    logic [RP*RS-1:0]  rd_data;
    logic [RP-1:0]     rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [RS-1:0]     wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              iss_ready;
    logic              clr_req;
    logic              clr_busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [RS:0]   exp_q [$];
    logic [RS-1:0] m_data [RN];
    logic          m_busy [RN];

    regfile_scoreboard #(.REG_NUM(RN), .REG_SIZE(RS), .READ_PORTS(RP), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; clr_req = 1'b0; rd_addr = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < RN; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // push the model's view of the register currently addressed on port p
    task automatic push_port(input int p);
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        if (a == 0) exp_q.push_back({1'b0, {RS{1'b0}}});
        else        exp_q.push_back({m_busy[a], m_data[a]});
    endtask

    task automatic test_reset();
        logic [RS:0] e;
        idle_inputs();
        model_clear();
        rst = 1'b1;
        #12;
        rd_addr = {AW'(31), AW'(5)};
        #1;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL reset_iss_ready got %b exp 1", iss_ready); else n_pass++;
        n_total++;
        if (clr_busy !== 1'b0) $display("FAIL reset_clr_busy got %b exp 0", clr_busy); else n_pass++;
        push_port(0); push_port(1);
        for (int p = 0; p < RP; p++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                $display("FAIL reset_read p%0d got %h exp %h", p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        logic [RS:0] e;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEAD_BEEF;
        @(posedge clk); m_data[5] = 32'hDEAD_BEEF; m_busy[5] = 1'b0;
        @(negedge clk);
        wr_addr = AW'(31); wr_data = 32'hA5A5_0F0F;
        rd_addr = {AW'(0), AW'(5)};
        push_port(0); push_port(1);
        #1;
        for (int p = 0; p < RP; p++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                $display("FAIL write_read p%0d got %h exp %h", p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
            else n_pass++;
        end
        @(posedge clk); m_data[31] = 32'hA5A5_0F0F;
        @(negedge clk);
        wr_en = 1'b0;
        rd_addr = {AW'(31), AW'(31)};
        push_port(0); push_port(1);
        #1;
        for (int p = 0; p < RP; p++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                $display("FAIL same_addr p%0d got %h exp %h", p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        logic [RS:0] e;
        @(negedge clk);
        iss_en = 1'b1; iss_addr = AW'(9);
        @(posedge clk); m_busy[9] = 1'b1;
        @(negedge clk);
        iss_en = 1'b0;
        wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h1234_5678;
        rd_addr = {AW'(9), AW'(7)};
        exp_q.push_back({1'b0, 32'h1234_5678});
        push_port(1);
        #1;
        for (int p = 0; p < RP; p++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                $display("FAIL bypass_r7 p%0d got %h exp %h", p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
            else n_pass++;
        end
        @(posedge clk); m_data[7] = 32'h1234_5678;
        @(negedge clk);
        wr_addr = AW'(9); wr_data = 32'h0000_0099;
        exp_q.push_back({m_busy[7], m_data[7]});
        exp_q.push_back({1'b0, 32'h0000_0099});
        #1;
        for (int p = 0; p < RP; p++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                $display("FAIL bypass_busy p%0d got %h exp %h", p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
            else n_pass++;
        end
        @(posedge clk); m_data[9] = 32'h0000_0099; m_busy[9] = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic test_issue();
        logic [RS:0] e;
        @(negedge clk);
        iss_en = 1'b1; iss_addr = AW'(3); rd_addr = {AW'(0), AW'(3)};
        #1;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL issue_first got %b exp 1", iss_ready); else n_pass++;
        @(posedge clk); m_busy[3] = 1'b1;
        @(negedge clk);
        push_port(0);
        #1;
        n_total++;
        if (iss_ready !== 1'b0) $display("FAIL issue_waw got %b exp 0", iss_ready); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if ({rd_busy[0], rd_data[RS-1:0]} !== e)
            $display("FAIL issue_busy got %h exp %h", {rd_busy[0], rd_data[RS-1:0]}, e);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'h0000_0033;
        exp_q.push_back({1'b0, 32'h0000_0033});
        #1;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL issue_retire got %b exp 1", iss_ready); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if ({rd_busy[0], rd_data[RS-1:0]} !== e)
            $display("FAIL issue_retire_rd got %h exp %h", {rd_busy[0], rd_data[RS-1:0]}, e);
        else n_pass++;
        @(posedge clk); m_data[3] = 32'h0000_0033; m_busy[3] = 1'b1;
        @(negedge clk);
        idle_inputs();
        rd_addr = {AW'(3), AW'(3)};
        push_port(0); push_port(1);
        #1;
        for (int p = 0; p < RP; p++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                $display("FAIL issue_wins p%0d got %h exp %h", p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
            else n_pass++;
        end
    endtask

    task automatic test_r0();
        logic [RS:0] e;
        @(negedge clk);
        iss_en = 1'b1; iss_addr = AW'(0);
        wr_en = 1'b1; wr_addr = AW'(0); wr_data = 32'hFFFF_FFFF;
        rd_addr = {AW'(0), AW'(0)};
        exp_q.push_back({1'b0, 32'h0000_0000});
        #1;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL r0_iss_ready got %b exp 1", iss_ready); else n_pass++;
        e = exp_q.pop_front();
        n_total++;
        if ({rd_busy[0], rd_data[RS-1:0]} !== e)
            $display("FAIL r0_same got %h exp %h", {rd_busy[0], rd_data[RS-1:0]}, e);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        exp_q.push_back({1'b0, 32'h0000_0000});
        #1;
        e = exp_q.pop_front();
        n_total++;
        if ({rd_busy[1], rd_data[2*RS-1:RS]} !== e)
            $display("FAIL r0_next got %h exp %h", {rd_busy[1], rd_data[2*RS-1:RS]}, e);
        else n_pass++;
    endtask

    task automatic fill_all();
        for (int a = 1; a < RN; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(a);
            wr_data = (32'(a) * 32'h0101_0101) ^ 32'h8000_0000;
            @(posedge clk); m_data[a] = wr_data; m_busy[a] = 1'b0;
        end
        @(negedge clk);
        wr_en = 1'b0;
        for (int a = 1; a < RN; a++) begin
            @(negedge clk);
            iss_en = 1'b1; iss_addr = AW'(a);
            @(posedge clk); m_busy[a] = 1'b1;
        end
        @(negedge clk);
        iss_en = 1'b0;
    endtask

    task automatic test_clear();
        logic [RS:0] e;
        fill_all();
        @(negedge clk);
        clr_req = 1'b1;
        #1;
        n_total++;
        if (clr_busy !== 1'b0) $display("FAIL clr_pre got %b exp 0", clr_busy); else n_pass++;
        @(posedge clk);
        for (int k = 1; k < RN; k++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = AW'(31); wr_data = 32'h0000_0BAD;
            iss_en = 1'b1; iss_addr = AW'(0);
            rd_addr = {AW'(k - 1), AW'(31)};
            exp_q.push_back({m_busy[31], m_data[31]});
            exp_q.push_back({1'b0, 32'h0000_0000});
            #1;
            n_total++;
            if (clr_busy !== 1'b1) $display("FAIL clr_busy cyc%0d got %b exp 1", k, clr_busy); else n_pass++;
            n_total++;
            if (iss_ready !== 1'b0) $display("FAIL clr_iss cyc%0d got %b exp 0", k, iss_ready); else n_pass++;
            for (int p = 0; p < RP; p++) begin
                e = exp_q.pop_front();
                n_total++;
                if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                    $display("FAIL clr_read cyc%0d p%0d got %h exp %h", k, p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
                else n_pass++;
            end
        end
        model_clear();
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++;
        if (clr_busy !== 1'b0) $display("FAIL clr_done got %b exp 0", clr_busy); else n_pass++;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL clr_iss_back got %b exp 1", iss_ready); else n_pass++;
        for (int a = 1; a < RN; a++) begin
            rd_addr = {AW'(RN - a), AW'(a)};
            push_port(0); push_port(1);
            #1;
            for (int p = 0; p < RP; p++) begin
                e = exp_q.pop_front();
                n_total++;
                if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                    $display("FAIL clr_after r%0d p%0d got %h exp %h", a, p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [RS:0] e;
        fill_all();
        @(negedge clk);
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rd_addr = {AW'(20), AW'(12)};
        #1;
        n_total++;
        if (clr_busy !== 1'b1) $display("FAIL midclr_running got %b exp 1", clr_busy); else n_pass++;
        #1 rst = 1'b1;
        model_clear();
        push_port(0); push_port(1);
        #1;
        n_total++;
        if (clr_busy !== 1'b0) $display("FAIL midclr_clr_busy got %b exp 0", clr_busy); else n_pass++;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL midclr_iss_ready got %b exp 1", iss_ready); else n_pass++;
        for (int p = 0; p < RP; p++) begin
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[p], rd_data[p*RS +: RS]} !== e)
                $display("FAIL midclr_read p%0d got %h exp %h", p, {rd_busy[p], rd_data[p*RS +: RS]}, e);
            else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (clr_busy !== 1'b0) $display("FAIL midclr_idle got %b exp 0", clr_busy); else n_pass++;
        for (int a = 1; a < RN; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            push_port(0);
            #1;
            e = exp_q.pop_front();
            n_total++;
            if ({rd_busy[0], rd_data[RS-1:0]} !== e)
                $display("FAIL midclr_after r%0d got %h exp %h", a, {rd_busy[0], rd_data[RS-1:0]}, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_issue();
        test_r0();
        test_clear();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
